pipe_reg: RTL and testbench
===========================

PIPE_REG -- requirements
Module: pipe_reg

Interface
- REQ-001: Parameter WIDTH, default 8, data width in bits; legal range 1..64.
- REQ-002: Parameter DEPTH, default 4, number of register stages; legal range 1..32.
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset  input  1  asynchronous, active-high reset.
- REQ-005: en  input  1  advance enable; while low, all stages, valid bits and fill hold.
- REQ-006: flush  input  1  synchronous clear of all valid bits; has priority over en.
- REQ-007: d_valid  input  1  qualifies d as a real sample.
- REQ-008: d  input  WIDTH  sample entering stage 0.
- REQ-009: q_valid  output  1  valid bit of stage DEPTH-1.
- REQ-010: q  output  WIDTH  data of stage DEPTH-1; registered, with no combinational path from d.
- REQ-011: fill  output  CW=$clog2(DEPTH+1)  count of valid stages, registered.
- REQ-012: full  output  1  high when fill==DEPTH.
- REQ-013: empty  output  1  high when fill==0.

Function
- REQ-014: On a rising edge with en=1 and flush=0, stage0<=d and valid0<=d_valid, and for each i>=1, stage i<=stage i-1 and valid i<=valid i-1.
- REQ-015: Latency: a sample presented with en high appears on q after exactly DEPTH rising edges of en-high cycles; en-low cycles are not counted.
- REQ-016: Data passes through stages unmodified; invalid samples still shift their data, but q_valid marks them invalid.
- REQ-017: On an edge with en=1, fill updates as fill + d_valid - valid[DEPTH-1]; on an edge with en=0, fill holds.
- REQ-018: Simultaneous entry and exit: fill is unchanged when d_valid=1 and valid[DEPTH-1]=1.
- REQ-019: fill never exceeds DEPTH and never underflows; fill saturates at DEPTH when all stages are valid.
- REQ-020: On an edge with flush=1, regardless of en, all valid bits, fill, and q_valid go to 0, and d/d_valid on that edge are discarded; empty is high the next cycle.
- REQ-021: Data registers are untouched by flush, except as REQ-028 states.
- REQ-022: full and empty are decoded from the fill register only; they never both assert, for any DEPTH>=1.
- REQ-023: With DEPTH=1, the block behaves as a single enabled D flip-flop plus a valid bit; fill is 0 or 1.

Reset
- REQ-024: While reset=1, all valid bits, q_valid and fill are 0, empty=1, full=0; this takes effect immediately, independent of clk.
- REQ-025: When reset asserts mid-operation, all in-flight samples are lost; no partial shift is visible after reset.
- REQ-026: After reset deasserts, the first en-high edge loads stage 0 normally.

Configuration
- REQ-027: Macro PIPE_REG_DATA_CLEAR_EN selects data-register clearing.
- REQ-028: With PIPE_REG_DATA_CLEAR_EN defined, reset and flush also clear every data stage, and q, to 0.
- REQ-029: Without PIPE_REG_DATA_CLEAR_EN, data stages have no reset, and q is undefined until DEPTH en-high cycles have elapsed; valid and fill behaviour is identical in both builds.

Structure
- REQ-030: Package pipe_reg_pkg holds the WIDTH/DEPTH default constants and a count-width function returning $clog2(DEPTH+1).
- REQ-031: Sub-module pipe_reg_stage holds one WIDTH-bit data register and its valid bit, with en, flush and async reset; pipe_reg instantiates DEPTH of them in a generate chain.
- REQ-032: The fill counter, full decode and empty decode live in pipe_reg, not in the stages.

Verification
- REQ-033: Reset, then en=1 and d_valid=1 with d=0x01,0x02,0x03,... per cycle at WIDTH=8 and DEPTH=4 -> q=0x01 with q_valid=1 on the 4th edge, then consecutive values; fill goes 1,2,3,4, then holds at 4 with full=1.
- REQ-034: Pipe filled to fill=4, then en=0 for 5 cycles -> q, q_valid and fill are frozen, and the d changes are ignored.
- REQ-035: Alternating d_valid=1,0,1,0 -> q_valid toggles 4 cycles later; fill settles at 2.
- REQ-036: fill=3 and flush=1 asserted together with en=1 and d_valid=1 -> next cycle fill=0, empty=1, q_valid=0, and the flushed-edge sample never appears on q.
- REQ-037: reset pulsed asynchronously between clock edges while fill=4 -> q_valid=0 and fill=0 before the next edge; with PIPE_REG_DATA_CLEAR_EN defined, q=0x00.
- REQ-038: DEPTH=1 build with d=0xA5 and d_valid=1 for one edge -> q=0xA5, q_valid=1 and full=1 after 1 edge; after the next edge with d_valid=0 -> q_valid=0 and empty=1.

Source files
------------

// File: rtl/pipe_reg_pkg.sv
// pipe_reg_pkg: default sizes and count-width helper for the pipe_reg slice
package pipe_reg_pkg;
   localparam int DEF_WIDTH = 8;
   localparam int DEF_DEPTH = 4;
   function automatic int cnt_w(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/pipe_reg_stage.sv
// pipe_reg_stage: one data register plus valid bit; PIPE_REG_DATA_CLEAR_EN adds data clear on reset/flush
module pipe_reg_stage
   import pipe_reg_pkg::*;
#(
   parameter int WIDTH = DEF_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d,
   output logic             q_valid,
   output logic [WIDTH-1:0] q
);
   logic             valid_d, valid_q;
   logic [WIDTH-1:0] data_d, data_q;
   // flush clears the valid bit; en advances; otherwise both hold
   always_comb begin
      valid_d = flush ? 1'b0 : (en ? d_valid : valid_q);
`ifdef PIPE_REG_DATA_CLEAR_EN
      data_d  = flush ? '0 : (en ? d : data_q);
`else
      data_d  = (en && !flush) ? d : data_q;
`endif
   end
   // valid bit is always reset so in-flight samples vanish immediately
   always_ff @(posedge clk or posedge reset)
      if (reset) valid_q <= 1'b0;
      else       valid_q <= valid_d;
`ifdef PIPE_REG_DATA_CLEAR_EN
   // data register cleared by reset when clearing is built in
   always_ff @(posedge clk or posedge reset)
      if (reset) data_q <= '0;
      else       data_q <= data_d;
`else
   // data register carries no reset
   always_ff @(posedge clk)
      data_q <= data_d;
`endif
   assign q_valid = valid_q;
   assign q       = data_q;
endmodule

// File: rtl/pipe_reg.sv
// pipe_reg: DEPTH-stage enabled pipeline with valid tracking and fill count; macro PIPE_REG_DATA_CLEAR_EN clears data on reset/flush
module pipe_reg
   import pipe_reg_pkg::*;
#(
   parameter  int WIDTH = DEF_WIDTH,
   parameter  int DEPTH = DEF_DEPTH,
   localparam int CW    = cnt_w(DEPTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             en,
   input  logic             flush,
   input  logic             d_valid,
   input  logic [WIDTH-1:0] d,
   output logic             q_valid,
   output logic [WIDTH-1:0] q,
   output logic [CW-1:0]    fill,
   output logic             full,
   output logic             empty
);
   logic [DEPTH:0]            sv;
   logic [DEPTH:0][WIDTH-1:0] sd;
   logic [CW-1:0]             fill_d, fill_q;
   assign sv[0] = d_valid;
   assign sd[0] = d;
   for (genvar g = 0; g < DEPTH; g++) begin : g_stage
      pipe_reg_stage #(.WIDTH(WIDTH)) u_stage (
         .clk     (clk),
         .reset   (reset),
         .en      (en),
         .flush   (flush),
         .d_valid (sv[g]),
         .d       (sd[g]),
         .q_valid (sv[g+1]),
         .q       (sd[g+1])
      );
   end
   // fill tracks valid stages: entry adds, exit subtracts, both together cancel
   always_comb
      fill_d = flush ? '0 : (en ? fill_q + CW'(d_valid) - CW'(sv[DEPTH]) : fill_q);
   // fill register with async reset
   always_ff @(posedge clk or posedge reset)
      if (reset) fill_q <= '0;
      else       fill_q <= fill_d;
   assign q_valid = sv[DEPTH];
   assign q       = sd[DEPTH];
   assign fill    = fill_q;
   assign full    = fill_q == CW'(DEPTH);
   assign empty   = fill_q == '0;
endmodule

// File: tb/tb_pipe_reg.sv
// tb_pipe_reg: randomized check of pipe_reg (DEPTH 4 and DEPTH 1) against a queue model
module tb_pipe_reg;
   typedef struct {
      bit         v;
      logic [7:0] d;
      bit         k;
   } ent_t;
`ifdef PIPE_REG_DATA_CLEAR_EN
   localparam bit CLR = 1'b1;
`else
   localparam bit CLR = 1'b0;
`endif
   logic       clk = 1'b0, reset = 1'b1, en = 1'b0, flush = 1'b0, dv = 1'b0;
   logic [7:0] d = 8'h00;
   logic       qv0, full0, empty0, qv1, full1, empty1;
   logic [7:0] q0, q1;
   logic [2:0] fill0;
   logic [0:0] fill1;
   int         n_cmp = 0, n_err = 0;
   ent_t       pq[2][$];
   always #5 clk = ~clk;
   pipe_reg #(.WIDTH(8), .DEPTH(4)) u0 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .d_valid(dv), .d(d),
      .q_valid(qv0), .q(q0), .fill(fill0), .full(full0), .empty(empty0)
   );
   pipe_reg #(.WIDTH(8), .DEPTH(1)) u1 (
      .clk(clk), .reset(reset), .en(en), .flush(flush), .d_valid(dv), .d(d),
      .q_valid(qv1), .q(q1), .fill(fill1), .full(full1), .empty(empty1)
   );
   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask
   task automatic mdl_reset();
      for (int i = 0; i < 2; i++) begin
         pq[i].delete();
         for (int j = 0; j < (i == 0 ? 4 : 1); j++) pq[i].push_back('{1'b0, 8'h00, CLR});
      end
   endtask
   task automatic mdl_edge();
      for (int i = 0; i < 2; i++)
         if (flush) begin
            for (int j = 0; j < pq[i].size(); j++) begin
               pq[i][j].v = 1'b0;
               if (CLR) pq[i][j].d = 8'h00;
               if (CLR) pq[i][j].k = 1'b1;
            end
         end else if (en) begin
            pq[i].push_front('{dv, d, 1'b1});
            void'(pq[i].pop_back());
         end
   endtask
   task automatic check_all(input string tag);
      int   f[2];
      ent_t l[2];
      for (int i = 0; i < 2; i++) begin
         f[i] = 0;
         for (int j = 0; j < pq[i].size(); j++) f[i] += int'(pq[i][j].v);
         l[i] = pq[i][pq[i].size()-1];
      end
      check({tag, ".qv0"}, qv0, l[0].v);
      check({tag, ".fill0"}, fill0, f[0]);
      check({tag, ".full0"}, full0, f[0] == 4);
      check({tag, ".empty0"}, empty0, f[0] == 0);
      if (l[0].k) check({tag, ".q0"}, q0, l[0].d);
      check({tag, ".qv1"}, qv1, l[1].v);
      check({tag, ".fill1"}, fill1, f[1]);
      check({tag, ".full1"}, full1, f[1] == 1);
      check({tag, ".empty1"}, empty1, f[1] == 0);
      if (l[1].k) check({tag, ".q1"}, q1, l[1].d);
   endtask
   task automatic step(input logic e, input logic fl, input logic v, input logic [7:0] dd, input string tag);
      en = e; flush = fl; dv = v; d = dd;
      @(posedge clk);
      mdl_edge();
      @(negedge clk);
      check_all(tag);
   endtask
   initial begin
      mdl_reset();
      #3;
      check_all("rst");
      check("rst.empty", empty0, 1);
      check("rst.full", full0, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int k = 1; k <= 8; k++) step(1, 0, 1, 8'(k), "ramp");
      check("ramp.full", full0, 1);
      check("ramp.q", q0, 8'h05);
      repeat (5) step(0, 0, 1'($urandom), 8'($urandom), "hold");
      check("hold.q", q0, 8'h05);
      check("hold.fill", fill0, 4);
      for (int k = 0; k < 8; k++) step(1, 0, k % 2 == 0, 8'(8'h20 + k), "alt");
      check("alt.fill", fill0, 2);
      step(0, 1, 0, 8'h00, "fl0");
      for (int k = 0; k < 3; k++) step(1, 0, 1, 8'(8'h10 + k), "fill3");
      check("fill3.fill", fill0, 3);
      step(1, 1, 1, 8'hEE, "flush");
      check("flush.fill", fill0, 0);
      check("flush.empty", empty0, 1);
      check("flush.qv", qv0, 0);
      repeat (4) step(1, 0, 0, 8'h00, "drain");
      repeat (300) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom), 8'($urandom), "rnd");
      repeat (4) step(1, 0, 1, 8'($urandom), "pre");
      check("pre.fill", fill0, 4);
      #2 reset = 1'b1;
      #1 mdl_reset();
      check_all("arst");
      check("arst.fill", fill0, 0);
      check("arst.qv", qv0, 0);
      #1 reset = 1'b0;
      step(1, 0, 1, 8'hA5, "d1a");
      check("d1a.q1", q1, 8'hA5);
      check("d1a.qv1", qv1, 1);
      check("d1a.full1", full1, 1);
      step(1, 0, 0, 8'h3C, "d1b");
      check("d1b.qv1", qv1, 0);
      check("d1b.empty1", empty1, 1);
      repeat (60) step($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, 1'($urandom), 8'($urandom), "rnd2");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
